pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage RV32 pipeline.
- Generates per-stage update enables and bubble-insert strobes for the IF_ID, ID_EX, EX_MA and MA_WB pipeline registers.
- Arbitrates three hazard sources: data-memory wait in MA, branch/jump redirect from EX, and load-use in ID.
- Owns the data-memory wait FSM with timeout, plus stall/flush performance counters.

Parameters:
- MEM_TIMEOUT, 16: max consecutive wait cycles before a memory error (range 1..255).
- CNT_W, 32: width of the performance counters.
- NOP_INST, 32'h00000013: bubble encoding (addi x0,x0,0), exported for the pipeline registers.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-high reset.
- id_inst  in  32  instruction currently in ID.
- ex_inst  in  32  instruction currently in EX.
- ma_inst  in  32  instruction currently in MA.
- ex_redirect  in  1  EX resolved a taken branch or jump this cycle.
- dmem_ready  in  1  data memory completes the current access.
- dmem_req  out  1  MA holds a load/store access request.
- if_en  out  1  PC / IF_ID update enable.
- id_en  out  1  ID_EX update enable.
- ex_en  out  1  EX_MA update enable.
- ma_en  out  1  MA_WB update enable.
- id_flush  out  1  load IF_ID with NOP_INST.
- ex_flush  out  1  load ID_EX with NOP_INST.
- wb_bubble  out  1  load MA_WB with NOP_INST.
- pc_redirect  out  1  PC takes the EX target.
- mem_err  out  1  sticky timeout flag.
- stall_cnt  out  CNT_W  stall cycles counted (wraps).
- flush_cnt  out  CNT_W  redirect flushes counted (wraps).

Behaviour:
Decode and timing
- Decode is local: opcode [6:0], rd [11:7], rs1 [19:15], rs2 [24:20].
- Load = 0000011; store = 0100011.
- rs1 is used by all opcodes except LUI, AUIPC and JAL.
- rs2 is used by R (0110011), S and B (1100011).
- All hazard outputs are combinational from state and inputs.
- State, timeout counter and perf counters update on posedge clk.
- Pipeline registers sample on negedge, so the outputs are stable half a cycle before use.

Memory wait
- mem_op = ma_inst is a load or store.
- dmem_req = mem_op && state != MEM_ERR.
- mem_stall = dmem_req && !dmem_ready.

FSM states
- RUN: mem_stall → MEM_WAIT, wait_cnt=1; otherwise stay in RUN.
- MEM_WAIT:
  - dmem_ready → RUN, wait_cnt=0.
  - wait_cnt==MEM_TIMEOUT && !dmem_ready → MEM_ERR.
  - Otherwise wait_cnt+1.
- MEM_ERR: sticky until reset; mem_err=1; all *_en=0; dmem_req=0; all flush outputs 0.

Priority, highest first
1. mem_stall:
   - if_en=id_en=ex_en=ma_en=0 and wb_bubble=1.
   - pc_redirect=0. A concurrent ex_redirect stays asserted by the frozen EX stage and is taken once the stall releases.
2. ex_redirect:
   - All en=1; id_flush=ex_flush=1; pc_redirect=1.
   - A load-use hazard in the same cycle is ignored, because the ID instruction is squashed.
3. load-use: ex_inst is a load, rd≠0, and rd matches id rs1 (if used) or rs2 (if used).
   - if_en=id_en=0; ex_flush=1; ex_en=ma_en=1.
   - Exactly one bubble; MA→EX forwarding covers the next cycle.
4. Otherwise: all en=1; all flush outputs 0.

Counters
- stall_cnt increments on every posedge where mem_stall or load-use stall is in effect.
- flush_cnt increments on every posedge where pc_redirect=1.
- Both wrap at 2^CNT_W.

Reset (asynchronous, any time, including mid-MEM_WAIT)
- state=RUN; wait_cnt=0; stall_cnt=flush_cnt=0; mem_err=0.
- With NOP inputs, outputs are: all en=1, all flush outputs 0, dmem_req=0, pc_redirect=0.

Boundary cases
- dmem_ready high in the same cycle the access reaches MA: no stall, state stays RUN.
- Back-to-back memory ops that each complete immediately: no stall.
- MEM_TIMEOUT=1: error after 1 full wait cycle.

Decomposition:
- Shared package rv32_pkg holds:
  - opcode localparams (OP_LOAD, OP_STORE, OP_BRANCH, OP_OP, OP_LUI, OP_AUIPC, OP_JAL);
  - NOP_INST;
  - FSM state encoding (RUN=2'd0, MEM_WAIT=2'd1, MEM_ERR=2'd2).
- One sub-module: inst_regs_used, a combinational decoder giving rd, rs1, rs2, uses_rs1, uses_rs2, is_load and is_store. It is instantiated three times (ID, EX, MA).

Test Plan:
- Load-use: ex_inst=lw x5,0(x1); id_inst=add x6,x5,x2 → one cycle of if_en=id_en=0 and ex_flush=1, then normal flow; stall_cnt=1.
- rd=x0: ex_inst=lw x0; id_inst uses x0 → no stall.
- Redirect combined with load-use: ex_redirect=1 with the above hazard → id_flush=ex_flush=1, pc_redirect=1, if_en=1; flush_cnt=1.
- Memory wait: ma_inst=sw, dmem_ready low for 3 cycles → en=0 and wb_bubble=1 for 3 cycles; a concurrent ex_redirect gives pc_redirect only on cycle 4; stall_cnt=3.
- Timeout: MEM_TIMEOUT=4, dmem_ready held low → mem_err=1 after 5 stall cycles, all en=0, dmem_req=0, sticky; assert reset mid-error → RUN, counters 0.
- Reset while in MEM_WAIT (wait_cnt=2), then dmem_ready=1 → RUN, no spurious stall; mem_err stays 0.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32 pipeline definitions: opcodes, bubble encoding, hazard FSM states
// and the decoded register-usage record.
package rv32_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // addi x0,x0,0 -- loaded into pipeline registers on flush/bubble
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_ERR  = 2'd2
    } mem_state_e;

    typedef struct packed {
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       uses_rs1;
        logic       uses_rs2;
        logic       is_load;
        logic       is_store;
    } inst_info_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard controller bus: instructions and status from the pipeline (master side)
// and the stall/flush controls plus counters returned by the controller (slave).
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      id_inst;
    logic [31:0]      ex_inst;
    logic [31:0]      ma_inst;
    logic             ex_redirect;
    logic             dmem_ready;

    logic             dmem_req;
    logic             if_en;
    logic             id_en;
    logic             ex_en;
    logic             ma_en;
    logic             id_flush;
    logic             ex_flush;
    logic             wb_bubble;
    logic             pc_redirect;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_inst, ex_inst, ma_inst, ex_redirect, dmem_ready,
        input  dmem_req, if_en, id_en, ex_en, ma_en, id_flush, ex_flush,
               wb_bubble, pc_redirect, mem_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_inst, ex_inst, ma_inst, ex_redirect, dmem_ready,
        output dmem_req, if_en, id_en, ex_en, ma_en, id_flush, ex_flush,
               wb_bubble, pc_redirect, mem_err, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/inst_regs_used.sv
// Combinational RV32 decoder: register fields, which source registers are
// actually read, and whether the instruction is a load or store.
module inst_regs_used
    import rv32_pkg::*;
(
    input  logic [31:0] inst_i,
    output inst_info_t  info_o
);

    logic [6:0] opcode;
    logic       unused_funct;

    assign opcode       = inst_i[6:0];
    assign unused_funct = ^{inst_i[31:25], inst_i[14:12]};

    always_comb begin
        info_o.rd       = inst_i[11:7];
        info_o.rs1      = inst_i[19:15];
        info_o.rs2      = inst_i[24:20];
        // U-type and JAL carry immediate bits where rs1 would sit
        info_o.uses_rs1 = !(opcode inside {OP_LUI, OP_AUIPC, OP_JAL});
        info_o.uses_rs2 = opcode inside {OP_OP, OP_STORE, OP_BRANCH};
        info_o.is_load  = (opcode == OP_LOAD);
        info_o.is_store = (opcode == OP_STORE);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage RV32 pipeline: memory-wait FSM
// with timeout, redirect and load-use arbitration, and stall/flush counters.
module pipe_hazard_ctrl
    import rv32_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               reset,
    pipe_hazard_ctrl_if.slave  hz
);

    localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

    inst_info_t id_info, ex_info, ma_info;

    inst_regs_used u_id_dec (.inst_i(hz.id_inst), .info_o(id_info));
    inst_regs_used u_ex_dec (.inst_i(hz.ex_inst), .info_o(ex_info));
    inst_regs_used u_ma_dec (.inst_i(hz.ma_inst), .info_o(ma_info));

    mem_state_e       state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic in_err, dmem_req, mem_stall, load_use;
    logic if_en, id_en, ex_en, ma_en;
    logic id_flush, ex_flush, wb_bubble, pc_redirect, stall_evt;

    assign in_err    = (state_q == MEM_ERR);
    assign dmem_req  = (ma_info.is_load || ma_info.is_store) && !in_err;
    assign mem_stall = dmem_req && !hz.dmem_ready;

    assign load_use = ex_info.is_load && (ex_info.rd != 5'd0) &&
                      ((id_info.uses_rs1 && (id_info.rs1 == ex_info.rd)) ||
                       (id_info.uses_rs2 && (id_info.rs2 == ex_info.rd)));

    // NOTE: every output of this block is given a default first so no path
    // through the priority chain leaves a signal unassigned (no latches).
    always_comb begin
        if_en       = 1'b1;
        id_en       = 1'b1;
        ex_en       = 1'b1;
        ma_en       = 1'b1;
        id_flush    = 1'b0;
        ex_flush    = 1'b0;
        wb_bubble   = 1'b0;
        pc_redirect = 1'b0;
        stall_evt   = 1'b0;

        if (in_err) begin
            if_en = 1'b0;
            id_en = 1'b0;
            ex_en = 1'b0;
            ma_en = 1'b0;
        end else if (mem_stall) begin
            // EX is frozen, so a pending redirect is simply re-presented later
            if_en     = 1'b0;
            id_en     = 1'b0;
            ex_en     = 1'b0;
            ma_en     = 1'b0;
            wb_bubble = 1'b1;
            stall_evt = 1'b1;
        end else if (hz.ex_redirect) begin
            id_flush    = 1'b1;
            ex_flush    = 1'b1;
            pc_redirect = 1'b1;
        end else if (load_use) begin
            if_en     = 1'b0;
            id_en     = 1'b0;
            ex_flush  = 1'b1;
            stall_evt = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        unique case (state_q)
            RUN: begin
                if (mem_stall) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = 8'd1;
                end
            end
            MEM_WAIT: begin
                if (hz.dmem_ready) begin
                    state_d    = RUN;
                    wait_cnt_d = 8'd0;
                end else if (wait_cnt_q == TIMEOUT_C) begin
                    state_d = MEM_ERR;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            MEM_ERR: state_d = MEM_ERR;
            default: begin
                state_d    = RUN;
                wait_cnt_d = 8'd0;
            end
        endcase

        if (stall_evt)   stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (pc_redirect) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of its peers regardless of evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            wait_cnt_q  <= 8'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.dmem_req    = dmem_req;
    assign hz.if_en       = if_en;
    assign hz.id_en       = id_en;
    assign hz.ex_en       = ex_en;
    assign hz.ma_en       = ma_en;
    assign hz.id_flush    = id_flush;
    assign hz.ex_flush    = ex_flush;
    assign hz.wb_bubble   = wb_bubble;
    assign hz.pc_redirect = pc_redirect;
    assign hz.mem_err     = in_err;
    assign hz.stall_cnt   = stall_cnt_q;
    assign hz.flush_cnt   = flush_cnt_q;

    logic unused_ok;
    assign unused_ok = ^{id_info.rd, id_info.is_load, id_info.is_store,
                         ex_info.rs1, ex_info.rs2, ex_info.uses_rs1,
                         ex_info.uses_rs2, ex_info.is_store,
                         ma_info.rd, ma_info.rs1, ma_info.rs2,
                         ma_info.uses_rs1, ma_info.uses_rs2};

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: expected control vectors are queued as
// each cycle is driven and compared at the following negedge.
module tb_pipe_hazard_ctrl;
    import rv32_pkg::*;

    localparam int CNT_W   = 32;
    localparam int TIMEOUT = 4;

    // {dmem_req, if_en, id_en, ex_en, ma_en, id_flush, ex_flush, wb_bubble, pc_redirect, mem_err}
    localparam logic [9:0] C_NORM   = 10'b0111100000;
    localparam logic [9:0] C_MEMOK  = 10'b1111100000;
    localparam logic [9:0] C_LU     = 10'b0001101000;
    localparam logic [9:0] C_REDIR  = 10'b0111111010;
    localparam logic [9:0] C_MREDIR = 10'b1111111010;
    localparam logic [9:0] C_MSTALL = 10'b1000000100;
    localparam logic [9:0] C_ERR    = 10'b0000000001;

    localparam logic [31:0] LW_X5   = 32'h0000A283; // lw  x5,0(x1)
    localparam logic [31:0] LW_X0   = 32'h0000A003; // lw  x0,0(x1)
    localparam logic [31:0] ADD_RS1 = 32'h00228333; // add x6,x5,x2
    localparam logic [31:0] ADD_RS2 = 32'h00510333; // add x6,x2,x5
    localparam logic [31:0] ADD_X0  = 32'h00000333; // add x6,x0,x0
    localparam logic [31:0] LUI_F5  = 32'h000283B7; // lui x7 with 5 in the rs1 field
    localparam logic [31:0] SW_X2   = 32'h0020A023; // sw  x2,0(x1)

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (bus)
    );

    typedef struct {
        string      tag;
        logic [9:0] ctl;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [9:0] ctl_obs;
    assign ctl_obs = {bus.dmem_req, bus.if_en, bus.id_en, bus.ex_en, bus.ma_en,
                      bus.id_flush, bus.ex_flush, bus.wb_bubble, bus.pc_redirect,
                      bus.mem_err};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check(e.tag, 64'(ctl_obs), 64'(e.ctl));
        end
    end

    task automatic set_in(input logic [31:0] id, input logic [31:0] ex, input logic [31:0] ma,
                          input logic redir, input logic rdy);
        bus.id_inst     = id;
        bus.ex_inst     = ex;
        bus.ma_inst     = ma;
        bus.ex_redirect = redir;
        bus.dmem_ready  = rdy;
    endtask

    // Called at posedge+1: apply one cycle of inputs and queue its expected controls.
    task automatic drive(input string tag, input logic [31:0] id, input logic [31:0] ex,
                         input logic [31:0] ma, input logic redir, input logic rdy,
                         input logic [9:0] exp);
        set_in(id, ex, ma, redir, rdy);
        sb_q.push_back('{tag, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string tag, input int s, input int f);
        check({tag, "_stall"}, 64'(bus.stall_cnt), 64'(s));
        check({tag, "_flush"}, 64'(bus.flush_cnt), 64'(f));
    endtask

    task automatic apply_reset(input string tag);
        reset = 1'b1;
        set_in(NOP_INST, NOP_INST, NOP_INST, 1'b0, 1'b0);
        #1;
        chk_cnt(tag, 0, 0);
        sb_q.push_back('{tag, C_NORM});
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        set_in(NOP_INST, NOP_INST, NOP_INST, 1'b0, 1'b0);
        #2;
        apply_reset("rst_init");
        @(posedge clk);
        #1;

        drive("lu_rs1",   ADD_RS1, LW_X5,    NOP_INST, 1'b0, 1'b1, C_LU);
        drive("lu_after", ADD_RS1, NOP_INST, LW_X5,    1'b0, 1'b1, C_MEMOK);
        chk_cnt("lu_rs1", 1, 0);
        drive("lu_rs2",   ADD_RS2, LW_X5,    NOP_INST, 1'b0, 1'b1, C_LU);
        chk_cnt("lu_rs2", 2, 0);

        drive("rd_x0",    ADD_X0,  LW_X0,    NOP_INST, 1'b0, 1'b0, C_NORM);
        drive("lui_norm", LUI_F5,  LW_X5,    NOP_INST, 1'b0, 1'b0, C_NORM);
        chk_cnt("no_stall", 2, 0);

        drive("redir_lu", ADD_RS1, LW_X5,    NOP_INST, 1'b1, 1'b0, C_REDIR);
        drive("redir_nx", NOP_INST, NOP_INST, NOP_INST, 1'b0, 1'b0, C_NORM);
        chk_cnt("redir", 2, 1);

        for (int i = 0; i < 3; i++)
            drive("mwait",    NOP_INST, NOP_INST, SW_X2, 1'b1, 1'b0, C_MSTALL);
        drive("mwait_rel",    NOP_INST, NOP_INST, SW_X2, 1'b1, 1'b1, C_MREDIR);
        chk_cnt("mwait", 5, 2);

        drive("b2b_lw",   NOP_INST, NOP_INST, LW_X5, 1'b0, 1'b1, C_MEMOK);
        drive("b2b_sw",   NOP_INST, NOP_INST, SW_X2, 1'b0, 1'b1, C_MEMOK);
        chk_cnt("b2b", 5, 2);

        drive("rw_wait1", NOP_INST, NOP_INST, SW_X2, 1'b0, 1'b0, C_MSTALL);
        drive("rw_wait2", NOP_INST, NOP_INST, SW_X2, 1'b0, 1'b0, C_MSTALL);
        apply_reset("rst_wait");
        drive("rw_mem",   NOP_INST, NOP_INST, SW_X2,    1'b0, 1'b1, C_MEMOK);
        drive("rw_nop",   NOP_INST, NOP_INST, NOP_INST, 1'b0, 1'b0, C_NORM);
        chk_cnt("rw", 0, 0);

        for (int i = 0; i < TIMEOUT + 1; i++)
            drive("to_wait",  NOP_INST, NOP_INST, LW_X5, 1'b0, 1'b0, C_MSTALL);
        drive("to_err",       NOP_INST, NOP_INST, LW_X5, 1'b0, 1'b0, C_ERR);
        chk_cnt("to", 5, 0);
        drive("err_redir",    ADD_RS1,  LW_X5,    LW_X5, 1'b1, 1'b0, C_ERR);
        drive("err_sticky",   NOP_INST, NOP_INST, LW_X5, 1'b0, 1'b1, C_ERR);
        chk_cnt("err", 5, 0);
        apply_reset("rst_err");
        drive("after_err",    NOP_INST, NOP_INST, NOP_INST, 1'b0, 1'b0, C_NORM);
        chk_cnt("after_err", 0, 0);

        check("sb_drain", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
